instr_encoder: RTL and testbench

//  Encodes decoded instruction fields (op, rd, rs1, rs2, imm) into 16-bit instruction words.

---
 rtl/instr_encoder.sv | 206 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Packs decoded instruction fields (op, rd, rs1, rs2, imm) into 16-bit
//   instruction words. The words are written into instruction memory at
//   consecutive addresses. This is the inverse of the core's instruction
//   decoder. The program loader and test harnesses use it.
//
//   Encoded words pass through a small FIFO, so the field-side handshake
//   keeps running while imem applies back-pressure.
//
// Parameters
//   ADDR_W      imem address width in words
//   FIFO_DEPTH  encoded-word buffer entries (power of 2, >= 2)
//   BASE_ADDR   first imem address written after start
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   start                 1-cycle pulse, begins a load session (IDLE/DONE only)
//   in_valid/in_ready     field-bundle handshake
//   in_op/rd/rs1/rs2/imm  decoded fields; in_last marks the final bundle
//   imem_we/addr/wdata    imem write port; imem_ready accepts the write
//   busy                  session active (LOAD or DRAIN)
//   done                  session finished (DONE state)
//   err/err_code          sticky first error: 1 illegal op, 2 imm range,
//                         3 address overflow
//   count                 words written this session
//
// Build option
//   ENC_RANGE_CHECK_EN  when defined, I/S/B immediates outside [-16,15] are
//                       rejected with err_code 2. When undefined, they are
//                       truncated to imm[4:0].
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rs1,
    input  logic [2:0]        in_rs2,
    input  logic [7:0]        in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   BASE_X   = {1'b0, BASE};
    localparam logic [ADDR_W:0]   LIMIT    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Field encoder
    // ------------------------------------------------------------------
    logic [15:0] word;
    logic        legal;
    logic        range_err;

    always_comb begin
        word  = '0;
        legal = 1'b1;
        if (in_op <= 5'd11)
            word = {in_op, in_rd, in_rs1, in_rs2, 2'b00};             // R
        else if (in_op >= 5'd16 && in_op <= 5'd20)
            word = {in_op, in_rd, in_rs1, in_imm[4:0]};               // I
        else if (in_op == 5'd24)
            word = {in_op, in_rs2, in_rs1, in_imm[4:0]};              // S
        else if (in_op >= 5'd25 && in_op <= 5'd28)
            word = {in_op, in_rs1, in_rs2, in_imm[4:0]};              // B
        else if (in_op == 5'd30)
            word = {in_op, 3'b000, in_imm};                           // J
        else
            legal = 1'b0;
    end

`ifdef ENC_RANGE_CHECK_EN
    // All legal ops with op[4] set are I/S/B/J, and only J is exempt.
    // The value fits in 5 signed bits when imm[7:5] all equal imm[4].
    assign range_err = legal && in_op[4] && (in_op != 5'd30) &&
                       (in_imm[7:5] != {3{in_imm[4]}});
`else
    assign range_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Word FIFO and address tracking
    // ------------------------------------------------------------------
    logic [15:0]       mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              empty, full;
    logic [ADDR_W-1:0] addr;
    // Address claimed by the next push. Overflow is decided here, not at
    // the imem side, so no more than 2^ADDR_W words are ever queued.
    logic [ADDR_W:0]   push_addr;
    logic              ovf;
    logic              fire, push, pop, start_ok, ovf_hit;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign ovf      = (push_addr == LIMIT);
    assign fire     = in_valid & in_ready;
    assign push     = fire & legal & ~range_err;
    assign pop      = imem_we & imem_ready;
    assign start_ok = start & ((state == IDLE) | (state == DONE));
    assign ovf_hit  = (state == LOAD) & in_valid & ovf;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[PTR_W-1:0]] <= word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            addr      <= BASE;
            push_addr <= BASE_X;
            count     <= '0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else if (start_ok) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            addr      <= BASE;
            push_addr <= BASE_X;
            count     <= '0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                push_addr <= push_addr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count + 1'b1;
                // Hold at the top address rather than wrap back to zero.
                if (addr != ADDR_MAX)
                    addr <= addr + 1'b1;
            end
            // Only the first error of a session is kept.
            if (!err) begin
                if (fire && !legal) begin
                    err      <= 1'b1;
                    err_code <= 2'd1;
                end else if (fire && range_err) begin
                    err      <= 1'b1;
                    err_code <= 2'd2;
                end else if (ovf_hit) begin
                    err      <= 1'b1;
                    err_code <= 2'd3;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Session FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD:  if ((fire && in_last) || ovf_hit) state_nxt = DRAIN;
            DRAIN: if (empty) state_nxt = DONE;
            DONE:  if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD) & ~full & ~ovf;
        busy     = (state == LOAD) | (state == DRAIN);
        done     = (state == DONE);
    end

    // The write strobe follows FIFO occupancy directly. Address and data
    // stay on the head entry until imem takes it.
    assign imem_we    = ~empty;
    assign imem_addr  = addr;
    assign imem_wdata = empty ? 16'h0000 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [2:0]  in_rd, in_rs1, in_rs2;
    logic [7:0]  in_imm;
    logic        in_last;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        imem_ready;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [8:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  wa[$];
    logic [15:0] wd[$];

    instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(2), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ready(imem_ready),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count)
    );

    always #5 clk = ~clk;

    // imem model: record every accepted write
    always @(posedge clk) begin
        if (reset && imem_we && imem_ready) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        wa.delete();
        wd.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [7:0] imm, input logic last);
        bit ok = 1'b0;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        imem_ready = 1'b1;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", 32'(imem_wdata), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // R-type ADD
        pulse_start();
        @(negedge clk);
        chk("add_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        send(5'b00000, 3'd1, 3'd2, 3'd3, 8'h00, 1'b1);
        wait_done("add_done");
        chk("add_nwr", 32'(wd.size()), 32'd1);
        if (wd.size() >= 1) begin
            chk("add_data", 32'(wd[0]), 32'h014C);
            chk("add_addr", 32'(wa[0]), 32'd0);
        end
        chk("add_count", 32'(count), 32'd1);
        chk("add_busy0", 32'(busy), 32'd0);

        // I-type LOAD then B-type BEQ
        pulse_start();
        send(5'b10001, 3'd2, 3'd1, 3'd0, 8'hFF, 1'b0);
        send(5'b11001, 3'd0, 3'd4, 3'd5, 8'hF0, 1'b1);
        wait_done("lb_done");
        chk("lb_nwr", 32'(wd.size()), 32'd2);
        if (wd.size() >= 2) begin
            chk("lb_d0", 32'(wd[0]), 32'h8A3F);
            chk("lb_a0", 32'(wa[0]), 32'd0);
            chk("lb_d1", 32'(wd[1]), 32'hCCB0);
            chk("lb_a1", 32'(wa[1]), 32'd1);
        end
        chk("lb_count", 32'(count), 32'd2);
        chk("lb_err", 32'(err), 32'd0);

        // JMP under back-pressure, FIFO fills
        imem_ready = 1'b0;
        pulse_start();
        send(5'b11110, 3'd0, 3'd0, 3'd0, 8'h80, 1'b0);
        send(5'b00000, 3'd1, 3'd2, 3'd3, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_we", 32'(imem_we), 32'd1);
            chk("bp_wdata", 32'(imem_wdata), 32'hF080);
            chk("bp_addr", 32'(imem_addr), 32'd0);
            chk("bp_full", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        imem_ready = 1'b1;
        send(5'b00000, 3'd1, 3'd2, 3'd3, 8'h00, 1'b1);
        wait_done("bp_done");
        chk("bp_nwr", 32'(wd.size()), 32'd3);
        if (wd.size() >= 3) begin
            chk("bp_d0", 32'(wd[0]), 32'hF080);
            chk("bp_d1", 32'(wd[1]), 32'h014C);
            chk("bp_a2", 32'(wa[2]), 32'd2);
        end
        chk("bp_count", 32'(count), 32'd3);

        // Out-of-range I immediate
        pulse_start();
        send(5'b10000, 3'd0, 3'd0, 3'd0, 8'd20, 1'b1);
        wait_done("rng_done");
`ifdef ENC_RANGE_CHECK_EN
        chk("rng_nwr", 32'(wd.size()), 32'd0);
        chk("rng_code", 32'(err_code), 32'd2);
        chk("rng_err", 32'(err), 32'd1);
`else
        chk("rng_nwr", 32'(wd.size()), 32'd1);
        if (wd.size() >= 1) chk("rng_data", 32'(wd[0]), 32'h8014);
        chk("rng_code", 32'(err_code), 32'd0);
        chk("rng_err", 32'(err), 32'd0);
`endif

        // Illegal opcode
        pulse_start();
        send(5'b11111, 3'd1, 3'd1, 3'd1, 8'h00, 1'b1);
        wait_done("ill_done");
        chk("ill_nwr", 32'(wd.size()), 32'd0);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_code", 32'(err_code), 32'd1);
        chk("ill_count", 32'(count), 32'd0);

        // Address overflow: 257 bundles
        pulse_start();
        for (int i = 0; i < 256; i++)
            send(5'b00000, 3'd1, 3'd2, 3'd3, 8'h00, 1'b0);
        in_valid = 1'b1;
        wait_done("ovf_done");
        in_valid = 1'b0;
        chk("ovf_nwr", 32'(wd.size()), 32'd256);
        if (wd.size() == 256) begin
            chk("ovf_a0", 32'(wa[0]), 32'd0);
            chk("ovf_a255", 32'(wa[255]), 32'd255);
        end
        chk("ovf_code", 32'(err_code), 32'd3);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_count", 32'(count), 32'd256);

        // Reset in the middle of DRAIN
        @(posedge clk); #1;
        imem_ready = 1'b0;
        pulse_start();
        send(5'b11110, 3'd0, 3'd0, 3'd0, 8'h80, 1'b1);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_we", 32'(imem_we), 32'd1);
        reset = 1'b0;
        #1;
        chk("mr_we", 32'(imem_we), 32'd0);
        chk("mr_wdata", 32'(imem_wdata), 32'd0);
        chk("mr_addr", 32'(imem_addr), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_ready", 32'(in_ready), 32'd0);
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        imem_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
